// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
// Shared definitions for the pulse-sequence loader: the loader FSM state
// enum, the host register map constants and the segment-duration entry width.
// Optional build macro used by the loader: PULSE_LOOP_EN (multi-pass looping).
// No ports (package).
// -----------------------------------------------------------------------------
package pulse_pkg;

  // One segment duration is 20 bits, moved to the generator as two words.
  localparam int ENTRY_W = 20;
  localparam int LO_W    = 16;
  localparam int HI_W    = ENTRY_W - LO_W;

  // Host register map. Entries start at 0 (low half) and ADDR_HI_BASE (high half).
  localparam int         ADDR_HI_BASE    = 16;
  localparam logic [4:0] ADDR_ERR_CLR    = 5'd29;
  localparam logic [4:0] ADDR_SEG_COUNT  = 5'd30;
  localparam logic [4:0] ADDR_LOOP_COUNT = 5'd31;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_LO   = 3'd1,
    LOAD_HI   = 3'd2,
    START     = 3'd3,
    WAIT_OVER = 3'd4,
    NEXT      = 3'd5,
    FIN       = 3'd6
  } state_e;

  // High half of an entry as presented on the 16-bit load bus.
  function automatic logic [LO_W-1:0] hi_word(input logic [ENTRY_W-1:0] e);
    return {{(LO_W-HI_W){1'b0}}, e[ENTRY_W-1:LO_W]};
  endfunction

endpackage

// File: rtl/pulse_seg_ram.sv
// -----------------------------------------------------------------------------
// pulse_seg_ram
// DEPTH x 20-bit segment-duration bank. One write port with separate enables
// for the low 16 bits and the high 4 bits (the host writes each half through
// its own address), combinational read. All entries clear on reset.
// Ports:
//   clk_sys, rst_n        clock / asynchronous active-low reset
//   wen_lo_i, wen_hi_i    write enables for entry[19:0] low / high part
//   waddr_i, wdata_i      write index and 20-bit write data
//   raddr_i, rdata_o      combinational read index and data
// -----------------------------------------------------------------------------
module pulse_seg_ram
  import pulse_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               wen_lo_i,
  input  logic               wen_hi_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wen_lo_i) begin
        mem_q[waddr_i][LO_W-1:0] <= wdata_i[LO_W-1:0];
      end
      if (wen_hi_i) begin
        mem_q[waddr_i][ENTRY_W-1:LO_W] <= wdata_i[ENTRY_W-1:LO_W];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pulse_seq_loader.sv
// -----------------------------------------------------------------------------
// pulse_seq_loader
// Loads a programmed list of 20-bit segment durations into an external pulse
// generator, one segment at a time: low word, high word, start strobe, then
// wait for the generator's active-low segment-over before the next segment.
// Optional build macro: PULSE_LOOP_EN -- adds loop_count (addr 31) and repeats
// the whole list loop_count+1 times. Without it one pass is run and writes to
// addr 31 do nothing.
// Ports:
//   clk_sys, rst_n          clock / asynchronous active-low reset
//   host_we/addr/data       host register write (ignored and flags err if busy)
//   host_go, host_abort     start a sequence / abandon it (abort wins)
//   pluseinter              active-low segment-over from the generator
//   pluseload, pluseloadchoice, plusedatain, plusestart   generator load bus
//   busy, done, err         status: running, one-cycle finish, sticky error
//   dbg_state               current FSM state
// Handshake: pluseload/plusestart are single-cycle strobes with no ready; the
// generator must accept them in the cycle they are high. pluseinter is only
// looked at while waiting for a segment to end.
// -----------------------------------------------------------------------------
module pulse_seq_loader
  import pulse_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_data,
  input  logic        host_go,
  input  logic        host_abort,
  input  logic        pluseinter,
  output logic        pluseload,
  output logic        pluseloadchoice,
  output logic [15:0] plusedatain,
  output logic        plusestart,
  output logic        busy,
  output logic        done,
  output logic        err,
  output state_e      dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   seg_count_q;
  logic [CNT_W-1:0]   seg_clamped;
  logic [ENTRY_W-1:0] rd_entry;
  logic [LO_W-1:0]    data_d;
  logic               wr_ok, is_lo, is_hi, err_d;
`ifdef PULSE_LOOP_EN
  logic [15:0]        loop_count_q;
  logic [15:0]        pass_q, pass_d;
`endif

  // ---------------------------------------------------------------- host side
  assign wr_ok = host_we && !busy;
  assign is_lo = int'(host_addr) < DEPTH;
  assign is_hi = (int'(host_addr) >= ADDR_HI_BASE) &&
                 (int'(host_addr) <  ADDR_HI_BASE + DEPTH);

  assign seg_clamped = (int'(host_data) > DEPTH) ? CNT_W'(DEPTH)
                                                 : host_data[CNT_W-1:0];

  // A write while busy only sets err; otherwise addr 29 clears it.
  always_comb begin
    err_d = err;
    if (host_we && busy) begin
      err_d = 1'b1;
    end else if (host_we && host_addr == ADDR_ERR_CLR) begin
      err_d = 1'b0;
    end
  end

  // Read port follows the next index so load data is registered together with
  // the strobe it belongs to.
  pulse_seg_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .wen_lo_i (wr_ok && is_lo),
    .wen_hi_i (wr_ok && is_hi),
    .waddr_i  (host_addr[IDX_W-1:0]),
    .wdata_i  ({host_data[HI_W-1:0], host_data}),
    .raddr_i  (idx_d),
    .rdata_o  (rd_entry)
  );

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef PULSE_LOOP_EN
    pass_d  = pass_q;
`endif
    if (host_abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host_go) begin
            idx_d   = '0;
            state_d = (seg_count_q != '0) ? LOAD_LO : FIN;
`ifdef PULSE_LOOP_EN
            pass_d  = loop_count_q;
`endif
          end
        end
        LOAD_LO:   state_d = LOAD_HI;
        LOAD_HI:   state_d = START;
        START:     state_d = WAIT_OVER;
        WAIT_OVER: if (!pluseinter) state_d = NEXT;
        NEXT: begin
          if ((CNT_W'(idx_q) + CNT_W'(1)) < seg_count_q) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD_LO;
`ifdef PULSE_LOOP_EN
          end else if (pass_q != '0) begin
            // Another full pass remains: wrap to the first entry.
            pass_d  = pass_q - 16'd1;
            idx_d   = '0;
            state_d = LOAD_LO;
`endif
          end else begin
            state_d = FIN;
          end
        end
        FIN: begin
          idx_d   = '0;
          state_d = IDLE;
        end
        default: begin
          idx_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    data_d = '0;
    if (state_d == LOAD_LO) begin
      data_d = rd_entry[LO_W-1:0];
    end else if (state_d == LOAD_HI) begin
      data_d = hi_word(rd_entry);
    end
  end

  // ------------------------------------------------ state, outputs, registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      seg_count_q     <= '0;
      err             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pluseload       <= 1'b0;
      pluseloadchoice <= 1'b0;
      plusedatain     <= '0;
      plusestart      <= 1'b0;
`ifdef PULSE_LOOP_EN
      loop_count_q    <= '0;
      pass_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      err             <= err_d;
      busy            <= (state_d != IDLE);
      done            <= (state_d == FIN);
      pluseload       <= (state_d == LOAD_LO) || (state_d == LOAD_HI);
      pluseloadchoice <= (state_d == LOAD_HI);
      plusedatain     <= data_d;
      plusestart      <= (state_d == START);
      if (wr_ok && host_addr == ADDR_SEG_COUNT) begin
        seg_count_q <= seg_clamped;
      end
`ifdef PULSE_LOOP_EN
      pass_q <= pass_d;
      if (wr_ok && host_addr == ADDR_LOOP_COUNT) begin
        loop_count_q <= host_data;
      end
`endif
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_seq_loader.sv
// -----------------------------------------------------------------------------
// tb_pulse_seq_loader
// Directed sequence of scenarios with random entry values, random segment-over
// delays and random pluseinter noise outside WAIT_OVER. A reference model
// (entry array, seg_count, loop_count, err) is updated on every host write and
// turned into a cycle-by-cycle expected trace of the outputs, which is
// compared against the DUT one cycle at a time.
// -----------------------------------------------------------------------------
module tb_pulse_seq_loader;
  import pulse_pkg::*;

  localparam int DEPTH = 8;

  // {busy, done, plusestart, pluseload, pluseloadchoice, plusedatain}
  typedef logic [20:0] obs_t;

  logic        clk_sys;
  logic        rst_n;
  logic        host_we;
  logic [4:0]  host_addr;
  logic [15:0] host_data;
  logic        host_go;
  logic        host_abort;
  logic        pluseinter;
  logic        pluseload;
  logic        pluseloadchoice;
  logic [15:0] plusedatain;
  logic        plusestart;
  logic        busy;
  logic        done;
  logic        err;
  state_e      dbg_state;

  pulse_seq_loader #(.DEPTH(DEPTH)) dut (
    .clk_sys         (clk_sys),
    .rst_n           (rst_n),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_data       (host_data),
    .host_go         (host_go),
    .host_abort      (host_abort),
    .pluseinter      (pluseinter),
    .pluseload       (pluseload),
    .pluseloadchoice (pluseloadchoice),
    .plusedatain     (plusedatain),
    .plusestart      (plusestart),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .dbg_state       (dbg_state)
  );

  // ------------------------------------------------------------ clock/reset
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // ------------------------------------------------------------------ model
  logic [19:0] mdl_entry [DEPTH];
  int          mdl_seg;
  int          mdl_loop;
  logic        mdl_err;

  obs_t        exp_q[$];
  logic [2:0]  drv_q[$];   // {host_we, host_abort, pluseinter} per cycle

  int n_checks = 0;
  int n_errors = 0;

  function automatic obs_t mk(input logic b, input logic dn, input logic st,
                              input logic ld, input logic ch, input logic [15:0] d);
    return {b, dn, st, ld, ch, d};
  endfunction

  function automatic obs_t obs_now();
    return {busy, done, plusestart, pluseload, pluseloadchoice, plusedatain};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int n_passes();
`ifdef PULSE_LOOP_EN
    return mdl_loop + 1;
`else
    return 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_entry[i] = '0;
    mdl_seg  = 0;
    mdl_loop = 0;
    mdl_err  = 1'b0;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk_sys);
    host_we   = 1'b1;
    host_addr = a;
    host_data = d;
    @(negedge clk_sys);
    host_we   = 1'b0;
    if (int'(a) < DEPTH) mdl_entry[int'(a)][15:0] = d;
    else if (int'(a) >= 16 && int'(a) < 16 + DEPTH) mdl_entry[int'(a) - 16][19:16] = d[3:0];
    else if (a == 5'd30) mdl_seg = (int'(d) > DEPTH) ? DEPTH : int'(d);
    else if (a == 5'd31) mdl_loop = int'(d);
    else if (a == 5'd29) mdl_err = 1'b0;
  endtask

  task automatic push(input obs_t o, input logic [2:0] dv);
    exp_q.push_back(o);
    drv_q.push_back(dv);
  endtask

  // Expected trace of one go: per segment lo word, hi word, start, d+1 wait
  // cycles (segment-over on the last), one gap cycle, then done and idle.
  task automatic plan_run(input int abort_seg, input int we_seg);
    int d;
    exp_q.delete();
    drv_q.delete();
    if (mdl_seg == 0) begin
      push(mk(1, 1, 0, 0, 0, 16'd0), 3'b001);
      push(mk(0, 0, 0, 0, 0, 16'd0), 3'b001);
      return;
    end
    for (int p = 0; p < n_passes(); p++) begin
      for (int i = 0; i < mdl_seg; i++) begin
        push(mk(1, 0, 0, 1, 0, mdl_entry[i][15:0]), {2'b00, rbit()});
        push(mk(1, 0, 0, 1, 1, {12'd0, mdl_entry[i][19:16]}), {2'b00, rbit()});
        push(mk(1, 0, 1, 0, 0, 16'd0), {2'b00, rbit()});
        d = $urandom_range(0, 3);
        for (int w = 0; w <= d; w++) begin
          if (p == 0 && i == abort_seg && w == d) begin
            push(mk(1, 0, 0, 0, 0, 16'd0), 3'b011);
            push(mk(0, 0, 0, 0, 0, 16'd0), 3'b001);
            return;
          end
          push(mk(1, 0, 0, 0, 0, 16'd0),
               {(p == 0 && i == we_seg && w == 0), 1'b0, (w != d)});
        end
        push(mk(1, 0, 0, 0, 0, 16'd0), {2'b00, rbit()});
      end
    end
    push(mk(1, 1, 0, 0, 0, 16'd0), 3'b001);
    push(mk(0, 0, 0, 0, 0, 16'd0), 3'b001);
  endtask

  task automatic run_plan(input string tag);
    obs_t e;
    int   cyc;
    cyc = 0;
    @(negedge clk_sys);
    host_go    = 1'b1;
    host_abort = 1'b0;
    pluseinter = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk_sys);
      host_go = 1'b0;
      cyc++;
      e = exp_q.pop_front();
      chk($sformatf("%s_cyc%0d", tag, cyc), 32'(obs_now()), 32'(e));
      {host_we, host_abort, pluseinter} = drv_q.pop_front();
    end
    host_we    = 1'b0;
    host_abort = 1'b0;
    pluseinter = 1'b1;
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst_n      = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    host_go    = 1'b0;
    host_abort = 1'b0;
    pluseinter = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_sys);
    chk("reset_outputs", 32'(obs_now()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_err", 32'(err), 32'd0);

    // Two-segment directed case.
    wr(5'd0, 16'h0010); wr(5'd16, 16'h0000);
    wr(5'd1, 16'hABCD); wr(5'd17, 16'h0003);
    wr(5'd30, 16'd2);
    chk("idle_write_no_err", 32'(err), 32'd0);
    plan_run(-1, -1); run_plan("two_seg");

    // Empty sequence: done straight away, no loads.
    wr(5'd30, 16'd0);
    plan_run(-1, -1); run_plan("empty");

    // Random contents and segment counts (counts above DEPTH clamp).
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        wr(5'(i), 16'($urandom));
        wr(5'(16 + i), 16'($urandom_range(0, 15)));
      end
      wr(5'd30, 16'($urandom_range(1, 12)));
      plan_run(-1, -1); run_plan($sformatf("rand%0d", r));
    end
    wr(5'd30, 16'd15);
    plan_run(-1, -1); run_plan("clamp");

    // Write while busy: flagged, ignored, cleared by addr 29.
    wr(5'd30, 16'd2);
    host_addr = 5'd0;
    host_data = 16'hFFFF;
    plan_run(-1, 0); run_plan("busy_write");
    mdl_err = 1'b1;
    chk("busy_write_err", 32'(err), 32'(mdl_err));
    plan_run(-1, -1); run_plan("entry_kept");
    chk("err_sticky", 32'(err), 32'(mdl_err));
    wr(5'd29, 16'd0);
    chk("err_clear", 32'(err), 32'(mdl_err));

    // Abort in the wait of the second of three segments, then restart.
    wr(5'd30, 16'd3);
    plan_run(1, -1); run_plan("abort");
    plan_run(-1, -1); run_plan("after_abort");

    // Loop count: three passes with the loop feature, one pass without.
    wr(5'd31, 16'd2);
    wr(5'd30, 16'd2);
    plan_run(-1, -1); run_plan("loop");
    wr(5'd31, 16'd0);

    // Reset in the middle of a load.
    @(negedge clk_sys);
    host_go = 1'b1;
    @(negedge clk_sys);
    host_go = 1'b0;
    chk("rst_mid_load", 32'(pluseload), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outputs", 32'({err, obs_now()}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_mid_idle", 32'(obs_now()), 32'd0);
    plan_run(-1, -1); run_plan("post_rst_empty");
    wr(5'd30, 16'd2);
    plan_run(-1, -1); run_plan("post_rst_zero_entries");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_seq_loader.md
PULSE_SEQ_LOADER -- requirements
Module: pulse_seq_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of 20-bit segment-duration entries (power of two).
REQ-002 SHALL have port clk_sys  in  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port host_we  in  1  host write strobe, one cycle.
REQ-005 SHALL have port host_addr  in  5  register address; map in REQ-012.
REQ-006 SHALL have port host_data  in  16  host write data.
REQ-007 SHALL have port host_go  in  1  start-sequence pulse.
REQ-008 SHALL have port host_abort  in  1  abort pulse.
REQ-009 SHALL have port pluseinter  in  1  active-low segment-over from the pulse generator.
REQ-010 SHALL have output ports pluseload (1), pluseloadchoice (1), plusedatain (16) and plusestart (1); these are the load interface to the pulse generator.
REQ-011 SHALL have output ports busy (1), done (1, one-cycle pulse) and err (1, sticky).

Function
REQ-012 SHALL decode host_addr as follows:
- 0..DEPTH-1: entry low 16 bits.
- 16..16+DEPTH-1: entry high 4 bits, from host_data[3:0].
- 30: seg_count (0..DEPTH).
- 31: loop_count (macro only).
- Any write to addr 29 clears err.
REQ-013 SHALL, while busy=1, ignore host_we and set err; register contents SHALL be unchanged.
REQ-014 SHALL clamp a seg_count write greater than DEPTH to DEPTH.
REQ-015 SHALL implement the FSM states IDLE, LOAD_LO, LOAD_HI, START, WAIT_OVER, NEXT and FIN.
REQ-016 SHALL move IDLE->LOAD_LO on host_go when seg_count>0; on host_go with seg_count=0 it SHALL go IDLE->FIN, and no load SHALL be issued.
REQ-017 SHALL, in LOAD_LO, drive plusedatain=entry[idx][15:0], pluseloadchoice=0 and pluseload=1 for exactly one cycle.
REQ-018 SHALL, in LOAD_HI, drive plusedatain={12'b0, entry[idx][19:16]}, pluseloadchoice=1 and pluseload=1 for exactly one cycle.
REQ-019 SHALL, in START, drive plusestart=1 for exactly one cycle, then enter WAIT_OVER.
REQ-020 SHALL, in WAIT_OVER, remain until pluseinter is sampled 0, then enter NEXT; pluseinter SHALL be ignored in all other states.
REQ-021 SHALL, in NEXT: if idx+1<seg_count, increment idx and go to LOAD_LO; otherwise go to FIN.
REQ-022 SHALL, in FIN, pulse done for one cycle, clear idx and return to IDLE.
REQ-023 SHALL hold busy=1 in every state except IDLE; host_go while busy SHALL be ignored.
REQ-024 SHALL, on host_abort in any state, go to IDLE on the next edge with no done pulse; all strobes SHALL be 0 from that cycle and idx SHALL be cleared. Abort SHALL have priority over go.
REQ-025 SHALL fix the latency from host_go to the first pluseload at 1 cycle, and from WAIT_OVER exit to the next pluseload at 1 cycle (via NEXT).
REQ-026 SHALL drive plusedatain=0 and pluseloadchoice=0 whenever pluseload=0.

Reset
REQ-027 SHALL, with rst_n low, asynchronously force: state=IDLE; busy, done, err, pluseload, pluseloadchoice and plusestart=0; plusedatain=0; idx=0; seg_count=0; loop_count=0; all entries=0.
REQ-028 SHALL, on reset asserted mid-sequence, deassert all strobes immediately and issue no done pulse.

Configuration
REQ-029 SHALL, with PULSE_LOOP_EN defined, make loop_count (16 bits) writable; FIN SHALL be reached only after loop_count+1 full passes over the entries, with NEXT wrapping idx to 0 and decrementing an internal pass counter.
REQ-030 SHALL, without PULSE_LOOP_EN, omit address 31 and the pass counter, execute exactly one pass, and treat writes to address 31 as no-ops.

Structure
REQ-031 SHALL place the state enum, register address constants and the 20-bit width constant in the shared package pulse_pkg.
REQ-032 SHALL implement the entry bank as the sub-module pulse_seg_ram: DEPTH x 20, one write port, combinational read.

Verification
REQ-033 SHALL cover: entries {0x00010, 0x3ABCD}, seg_count=2, go -> loads 0x0010/0x0000 then 0xABCD/0x0003, each followed by a one-cycle plusestart, and done one cycle after the second pluseinter=0.
REQ-034 SHALL cover: seg_count=0, go -> done on the next cycle, no pluseload or plusestart.
REQ-035 SHALL cover: host_we during WAIT_OVER -> err=1 and entry unchanged; a write to addr 29 -> err=0.
REQ-036 SHALL cover: abort during WAIT_OVER of segment 1 of 3 -> busy=0 next cycle, no done; a later go restarts at idx 0.
REQ-037 SHALL cover, with PULSE_LOOP_EN defined: loop_count=2, seg_count=2 -> 6 plusestart pulses in entry order 0,1,0,1,0,1, then a single done.
REQ-038 SHALL cover: rst_n low while pluseload=1 -> all outputs 0 immediately, and the FSM is in IDLE after release.
